// File: rtl/mem_interface_pkg.sv
// Shared types for the data-memory interface and the MEM-stage load/store unit.
package mem_interface_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic            ready;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
  } mem_resp_t;

  typedef enum logic [1:0] {
    SizeByte    = 2'd0,
    SizeHalf    = 2'd1,
    SizeWord    = 2'd2,
    SizeIllegal = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ExcLdMisalign  = 2'd0,
    ExcStMisalign  = 2'd1,
    ExcBusTimeout  = 2'd2,
    ExcIllegalSize = 2'd3
  } lsu_exc_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StResp  = 3'd2,
    StDone  = 3'd3,
    StDrain = 3'd4
  } lsu_state_e;

  function automatic logic [3:0] lane_be(mem_size_e size, logic [1:0] off);
    case (size)
      SizeByte: return 4'b0001 << off;
      SizeHalf: return 4'b0011 << off;
      default:  return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: shift the addressed lane down and sign/zero-extend by access size.
module mem_load_align
  import mem_interface_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  mem_size_e       size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    case (size_i)
      SizeByte: data_o = {{(XLEN-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
      SizeHalf: data_o = {{(XLEN-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
      default:  data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one op at a time toward data memory, with lane steering,
// load extension, and one-cycle misalign / illegal-size / bus-timeout exceptions.
module mem_lsu
  import mem_interface_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          MISALIGN_EXC   = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  input  logic            ex_load_i,
  input  logic            ex_store_i,
  input  logic [1:0]      ex_size_i,
  input  logic            ex_unsigned_i,
  input  logic [XLEN-1:0] ex_addr_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_rdata_o,
  output logic            exc_valid_o,
  output logic [1:0]      exc_cause_o,
  output logic [XLEN-1:0] exc_addr_o,
  output mem_req_t        d_req_o,
  input  mem_resp_t       d_resp_i
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast =
      CntW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q, fault_addr_q, ld_data_q, wb_hold_q;
  logic [3:0]      be_q;
  logic            we_q, load_q, uns_q, exc_q;
  logic [1:0]      off_q;
  mem_size_e       size_q;
  lsu_exc_e        cause_q, cause_d;
  logic [CntW-1:0] tmo_q;

  logic            mem_op, accept, misaligned, set_exc, capture, waiting, timed_out, done_ok;
  mem_size_e       ex_size;
  logic [XLEN-1:0] eff_addr, align_data;

  assign ex_size    = mem_size_e'(ex_size_i);
  assign mem_op     = ex_valid_i & (ex_load_i | ex_store_i);
  assign accept     = (state_q == StIdle) & mem_op & ~flush_i;
  assign misaligned = ((ex_size == SizeHalf) & ex_addr_i[0]) |
                      ((ex_size == SizeWord) & (|ex_addr_i[1:0]));
  assign waiting    = (state_q == StReq) | (state_q == StResp) | (state_q == StDrain);
  assign timed_out  = (TIMEOUT_CYCLES != 0) && (tmo_q == CntLast);

  // Without misalign exceptions the access is silently aligned down to its natural size.
  always_comb begin
    eff_addr = ex_addr_i;
    if (!MISALIGN_EXC) begin
      if (ex_size == SizeHalf) eff_addr[0] = 1'b0;
      if (ex_size == SizeWord) eff_addr[1:0] = 2'b00;
    end
  end

  mem_load_align u_load_align (
    .rdata_i    (d_resp_i.rdata),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (align_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    set_exc = 1'b0;
    cause_d = ExcBusTimeout;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (ex_size == SizeIllegal) begin
            state_d = StDone;
            set_exc = 1'b1;
            cause_d = ExcIllegalSize;
          end else if (MISALIGN_EXC && misaligned) begin
            state_d = StDone;
            set_exc = 1'b1;
            cause_d = ex_load_i ? ExcLdMisalign : ExcStMisalign;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (d_resp_i.ready) begin
          // A store is committed once ready is seen, even if flushed in that cycle.
          if (!load_q)              state_d = flush_i ? StIdle : StDone;
          else if (flush_i)         state_d = d_resp_i.rvalid ? StIdle : StDrain;
          else if (d_resp_i.rvalid) begin
            capture = 1'b1;
            state_d = StDone;
          end else                  state_d = StResp;
        end else if (flush_i) begin
          state_d = StIdle;
        end else if (timed_out) begin
          state_d = StDone;
          set_exc = 1'b1;
        end
      end
      StResp: begin
        if (flush_i) begin
          state_d = d_resp_i.rvalid ? StIdle : StDrain;
        end else if (d_resp_i.rvalid) begin
          capture = 1'b1;
          state_d = StDone;
        end else if (timed_out) begin
          state_d = StDone;
          set_exc = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      StDrain: if (d_resp_i.rvalid || timed_out) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      load_q       <= 1'b0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      size_q       <= SizeByte;
      fault_addr_q <= '0;
      exc_q        <= 1'b0;
      cause_q      <= ExcLdMisalign;
      ld_data_q    <= '0;
      wb_hold_q    <= '0;
      tmo_q        <= '0;
    end else begin
      if (accept) begin
        addr_q       <= eff_addr;
        wdata_q      <= ex_wdata_i << {eff_addr[1:0], 3'b000};
        be_q         <= lane_be(ex_size, eff_addr[1:0]);
        we_q         <= ~ex_load_i;
        load_q       <= ex_load_i;
        uns_q        <= ex_unsigned_i;
        off_q        <= eff_addr[1:0];
        size_q       <= ex_size;
        fault_addr_q <= ex_addr_i;
        exc_q        <= set_exc;
        cause_q      <= cause_d;
      end else if (set_exc) begin
        exc_q   <= 1'b1;
        cause_q <= cause_d;
      end
      if (capture)    ld_data_q <= align_data;
      if (wb_valid_o) wb_hold_q <= ld_data_q;
      if (state_d != state_q) tmo_q <= '0;
      else if (waiting)       tmo_q <= tmo_q + CntW'(1);
    end
  end

  always_comb begin
    done_ok       = (state_q == StDone) & ~flush_i;
    d_req_o.valid = (state_q == StReq);
    d_req_o.we    = we_q;
    d_req_o.addr  = addr_q;
    d_req_o.be    = be_q;
    d_req_o.wdata = wdata_q;
    // Gated by reset so a held EX op cannot show a stall while the unit is being reset.
    stall_o       = ~rst_i & (accept | waiting);
    wb_valid_o    = done_ok & load_q & ~exc_q;
    wb_rdata_o    = wb_valid_o ? ld_data_q : wb_hold_q;
    exc_valid_o   = done_ok & exc_q;
    exc_cause_o   = exc_valid_o ? cause_q : 2'd0;
    exc_addr_o    = exc_valid_o ? fault_addr_q : '0;
  end

endmodule
